aq_mmu_jtlb_data_ctrl: RTL and testbench

//  Access controller sitting directly upstream of the JTLB data array (64 idx x 2 ways x 44b).

---
 rtl/aq_mmu_jtlb_pkg.sv | 28 ++
 rtl/aq_mmu_jtlb_inv_sweep.sv | 70 +++++++
 rtl/aq_mmu_jtlb_data_ctrl.sv | 92 +++++++++
 tb/tb_aq_mmu_jtlb_data_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aq_mmu_jtlb_pkg.sv
// rtl/aq_mmu_jtlb_pkg.sv - shared constants and types for the JTLB data array controller
// Purpose: array geometry, invalidate-all FSM state encoding and way-mask constants.
package aq_mmu_jtlb_pkg;

    localparam int IDX_W     = 6;
    localparam int WAY_W     = 44;
    localparam int DEPTH     = 64;
    localparam int ARR_IDX_W = 9;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    localparam logic [1:0] WAY_NONE = 2'b00;
    localparam logic [1:0] WAY_0    = 2'b01;
    localparam logic [1:0] WAY_1    = 2'b10;
    localparam logic [1:0] WAY_BOTH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } inv_state_t;

    // Zero-extend an array index to the physical index port width.
    function automatic logic [ARR_IDX_W-1:0] arr_idx(input logic [IDX_W-1:0] idx);
        return {{(ARR_IDX_W-IDX_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/aq_mmu_jtlb_inv_sweep.sv
// rtl/aq_mmu_jtlb_inv_sweep.sv - invalidate-all sweep FSM and index counter
// Purpose: on inv_all_req in IDLE, walks every array index once, then pulses done.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   inv_all_req    level request, only looked at in IDLE
//   busy           high in SWEEP and DONE
//   done           one-cycle pulse (DONE state)
//   sweep_cen      high while SWEEP is driving the array
//   sweep_idx      index being cleared this cycle
module aq_mmu_jtlb_inv_sweep
    import aq_mmu_jtlb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inv_all_req,
    output logic             busy,
    output logic             done,
    output logic             sweep_cen,
    output logic [IDX_W-1:0] sweep_idx
);

    inv_state_t       state;
    logic [IDX_W-1:0] cnt;

    // Outputs are registered alongside the state so they line up with it exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sweep_cen <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (inv_all_req) begin
                        state     <= ST_SWEEP;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        sweep_cen <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    // Counter wraps naturally to 0 after the last index.
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        state     <= ST_DONE;
                        sweep_cen <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    sweep_cen <= 1'b0;
                end
            endcase
        end
    end

    assign sweep_idx = cnt;

endmodule

// File: rtl/aq_mmu_jtlb_data_ctrl.sv
// rtl/aq_mmu_jtlb_data_ctrl.sv - JTLB data array port arbiter and read-data formatter
// Purpose: arbitrates invalidate-all sweep > refill write > lookup read onto the single
//          array port and holds the last read result.
// Ports:
//   forever_cpuclk, cpurst                  clock, asynchronous active-high reset
//   rd_req/rd_idx/rd_grant                  lookup read request
//   rd_vld/rd_way0_data/rd_way1_data        read result, valid one cycle after grant
//   wr_req/wr_idx/wr_way/wr_data/wr_grant   refill write request
//   inv_all_req/inv_all_busy/inv_all_done   invalidate-all control
//   jtlb_data_cen/wen/idx/din/dout          array port
module aq_mmu_jtlb_data_ctrl
    import aq_mmu_jtlb_pkg::*;
(
    input  logic                 forever_cpuclk,
    input  logic                 cpurst,
    input  logic                 rd_req,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_grant,
    output logic                 rd_vld,
    output logic [WAY_W-1:0]     rd_way0_data,
    output logic [WAY_W-1:0]     rd_way1_data,
    input  logic                 wr_req,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [1:0]           wr_way,
    input  logic [WAY_W-1:0]     wr_data,
    output logic                 wr_grant,
    input  logic                 inv_all_req,
    output logic                 inv_all_busy,
    output logic                 inv_all_done,
    output logic                 jtlb_data_cen,
    output logic [1:0]           jtlb_data_wen,
    output logic [ARR_IDX_W-1:0] jtlb_data_idx,
    output logic [2*WAY_W-1:0]   jtlb_data_din,
    input  logic [2*WAY_W-1:0]   jtlb_data_dout
);

    logic               sweep_cen;
    logic [IDX_W-1:0]   sweep_idx;
    logic [2*WAY_W-1:0] hold;

    aq_mmu_jtlb_inv_sweep u_inv_sweep (
        .clk         (forever_cpuclk),
        .rst         (cpurst),
        .inv_all_req (inv_all_req),
        .busy        (inv_all_busy),
        .done        (inv_all_done),
        .sweep_cen   (sweep_cen),
        .sweep_idx   (sweep_idx)
    );

    // Requesters only get the port while the sweep FSM is idle.
    assign wr_grant = ~inv_all_busy & wr_req;
    assign rd_grant = ~inv_all_busy & rd_req & ~wr_req;

    always_comb begin
        jtlb_data_cen = 1'b0;
        jtlb_data_wen = WAY_NONE;
        jtlb_data_idx = '0;
        jtlb_data_din = '0;
        if (sweep_cen) begin
            jtlb_data_cen = 1'b1;
            jtlb_data_wen = WAY_BOTH;
            jtlb_data_idx = arr_idx(sweep_idx);
        end else if (wr_grant) begin
            // An empty way mask is consumed without touching the array.
            jtlb_data_cen = |wr_way;
            jtlb_data_wen = wr_way;
            jtlb_data_idx = arr_idx(wr_idx);
            jtlb_data_din = {wr_data, wr_data};
        end else if (rd_grant) begin
            jtlb_data_cen = 1'b1;
            jtlb_data_idx = arr_idx(rd_idx);
        end
    end

    // Array returns data the cycle after a read; keep it so it stays stable afterwards.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            rd_vld <= 1'b0;
            hold   <= '0;
        end else begin
            rd_vld <= rd_grant;
            if (rd_vld) begin
                hold <= jtlb_data_dout;
            end
        end
    end

    assign rd_way0_data = rd_vld ? jtlb_data_dout[WAY_W-1:0]       : hold[WAY_W-1:0];
    assign rd_way1_data = rd_vld ? jtlb_data_dout[2*WAY_W-1:WAY_W] : hold[2*WAY_W-1:WAY_W];

endmodule

// File: tb/tb_aq_mmu_jtlb_data_ctrl.sv
// tb/tb_aq_mmu_jtlb_data_ctrl.sv - scoreboard bench for the JTLB data array controller
module tb_aq_mmu_jtlb_data_ctrl;
    import aq_mmu_jtlb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req = 0, wr_req = 0, inv_all_req = 0;
    logic [5:0]  rd_idx = 0, wr_idx = 0;
    logic [1:0]  wr_way = 0;
    logic [43:0] wr_data = 0;
    logic        rd_grant, rd_vld, wr_grant, inv_all_busy, inv_all_done;
    logic [43:0] rd_way0_data, rd_way1_data;
    logic        jtlb_data_cen;
    logic [1:0]  jtlb_data_wen;
    logic [8:0]  jtlb_data_idx;
    logic [87:0] jtlb_data_din;
    logic [87:0] jtlb_data_dout = '0;

    always #5 clk = ~clk;

    aq_mmu_jtlb_data_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .rd_req         (rd_req),
        .rd_idx         (rd_idx),
        .rd_grant       (rd_grant),
        .rd_vld         (rd_vld),
        .rd_way0_data   (rd_way0_data),
        .rd_way1_data   (rd_way1_data),
        .wr_req         (wr_req),
        .wr_idx         (wr_idx),
        .wr_way         (wr_way),
        .wr_data        (wr_data),
        .wr_grant       (wr_grant),
        .inv_all_req    (inv_all_req),
        .inv_all_busy   (inv_all_busy),
        .inv_all_done   (inv_all_done),
        .jtlb_data_cen  (jtlb_data_cen),
        .jtlb_data_wen  (jtlb_data_wen),
        .jtlb_data_idx  (jtlb_data_idx),
        .jtlb_data_din  (jtlb_data_din),
        .jtlb_data_dout (jtlb_data_dout)
    );

    // SRAM model driven by the DUT's array port.
    logic [43:0] arr [64][2];
    always @(posedge clk) begin
        if (jtlb_data_cen) begin
            if (jtlb_data_wen == 2'b00)
                jtlb_data_dout <= {arr[jtlb_data_idx[5:0]][1], arr[jtlb_data_idx[5:0]][0]};
            if (jtlb_data_wen[0]) arr[jtlb_data_idx[5:0]][0] <= jtlb_data_din[43:0];
            if (jtlb_data_wen[1]) arr[jtlb_data_idx[5:0]][1] <= jtlb_data_din[87:44];
        end
    end

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: expected table contents, sweep position, pending done cycle.
    logic [43:0] gold [64][2];
    int          m_sweep = -1;
    bit          m_done = 0;
    bit          last_wg, last_rg;

    typedef struct {
        int          cyc;
        logic [87:0] data;
    } rd_exp_t;
    rd_exp_t rq[$];

    always @(posedge clk) cyc++;

    // Monitor: pairs every rd_vld with the oldest expected read, otherwise checks hold.
    initial begin : monitor
        logic [87:0] last_rd;
        rd_exp_t     e;
        bit          exp_v;
        last_rd = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                last_rd = '0;
            end else begin
                exp_v = (rq.size() > 0) && (rq[0].cyc == cyc);
                chk("rd_vld", rd_vld, exp_v);
                if (exp_v) begin
                    e = rq.pop_front();
                    chk("rd_data", {rd_way1_data, rd_way0_data}, e.data);
                    last_rd = e.data;
                end else begin
                    chk("rd_hold", {rd_way1_data, rd_way0_data}, last_rd);
                end
            end
        end
    end

    task automatic step(input bit w, input bit r, input bit inv, input logic [5:0] widx,
                        input logic [1:0] way, input logic [43:0] wd, input logic [5:0] ridx);
        bit          e_wg, e_rg, e_busy, e_done, e_cen;
        logic [1:0]  e_wen;
        logic [8:0]  e_idx;
        logic [87:0] e_din;
        @(negedge clk);
        wr_req = w; rd_req = r; inv_all_req = inv;
        wr_idx = widx; wr_way = way; wr_data = wd; rd_idx = ridx;
        #2;
        e_wg = 0; e_rg = 0; e_busy = 0; e_done = 0;
        e_cen = 0; e_wen = 0; e_idx = 0; e_din = 0;
        if (m_sweep >= 0) begin
            e_busy = 1; e_cen = 1; e_wen = 2'b11; e_idx = 9'(m_sweep);
        end else if (m_done) begin
            e_busy = 1; e_done = 1;
        end else if (w) begin
            e_wg = 1; e_cen = (way != 0); e_wen = way; e_idx = {3'b0, widx}; e_din = {wd, wd};
        end else if (r) begin
            e_rg = 1; e_cen = 1; e_idx = {3'b0, ridx};
        end
        chk("wr_grant", wr_grant, e_wg);
        chk("rd_grant", rd_grant, e_rg);
        chk("busy", inv_all_busy, e_busy);
        chk("done", inv_all_done, e_done);
        chk("cen", jtlb_data_cen, e_cen);
        chk("wen", jtlb_data_wen, e_wen);
        chk("idx", jtlb_data_idx, e_idx);
        chk("din", jtlb_data_din, e_din);
        last_wg = e_wg; last_rg = e_rg;
        if (m_sweep >= 0) begin
            gold[m_sweep][0] = '0; gold[m_sweep][1] = '0;
            if (m_sweep == 63) begin m_sweep = -1; m_done = 1; end
            else m_sweep++;
        end else if (m_done) begin
            m_done = 0;
        end else begin
            if (e_wg) begin
                if (way[0]) gold[widx][0] = wd;
                if (way[1]) gold[widx][1] = wd;
            end
            if (e_rg) rq.push_back('{cyc + 1, {gold[ridx][1], gold[ridx][0]}});
            if (inv) m_sweep = 0;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int          n;
        bit          wp, rp;
        logic [5:0]  wi, ri;
        logic [1:0]  wy;
        logic [43:0] wd;
        for (int i = 0; i < 64; i++) begin
            arr[i][0] = '0; arr[i][1] = '0; gold[i][0] = '0; gold[i][1] = '0;
        end
        // Reset state
        repeat (2) @(negedge clk);
        #2;
        chk("rst_busy", inv_all_busy, 0);
        chk("rst_done", inv_all_done, 0);
        chk("rst_rd_vld", rd_vld, 0);
        chk("rst_cen", jtlb_data_cen, 0);
        chk("rst_data", {rd_way1_data, rd_way0_data}, 0);
        rst = 0;
        repeat (10) step(0, 0, 0, 6'd3, 2'b11, 44'h123, 6'd9);

        // Directed write, read and hold
        step(1, 0, 0, 6'd5, 2'b10, 44'hABC, 6'd0);
        step(0, 1, 0, 6'd0, 2'b00, 44'h0, 6'd5);
        repeat (5) step(0, 0, 0, 6'd0, 2'b00, 44'h0, 6'd0);

        // Simultaneous write and read: write wins, read follows
        step(1, 1, 0, 6'd7, 2'b01, 44'h5A5A5, 6'd7);
        chk("pri_wr_first", {last_wg, last_rg}, 2'b10);
        step(0, 1, 0, 6'd7, 2'b01, 44'h5A5A5, 6'd7);
        chk("pri_rd_second", {last_wg, last_rg}, 2'b01);
        step(1, 0, 0, 6'd7, 2'b00, 44'hFFFF, 6'd0);

        // Read granted right before sweep, then a read held through the sweep
        step(0, 1, 1, 6'd0, 2'b00, 44'h0, 6'd5);
        n = 0;
        do begin
            step(0, 1, 0, 6'd0, 2'b00, 44'h0, 6'd5);
            n++;
        end while (!last_rg && n < 100);
        chk("sweep_len", n, 66);
        repeat (2) step(0, 0, 0, 6'd0, 2'b00, 44'h0, 6'd0);

        // Reset in the middle of a sweep
        step(1, 0, 0, 6'd20, 2'b11, 44'h777, 6'd0);
        step(0, 0, 1, 6'd0, 2'b00, 44'h0, 6'd0);
        n = 0;
        while (m_sweep != 20 && n < 100) begin
            step(0, 0, 0, 6'd0, 2'b00, 44'h0, 6'd0);
            n++;
        end
        @(negedge clk);
        #2;
        chk("mid_idx", jtlb_data_idx, 9'd20);
        #1 rst = 1;
        #1;
        chk("mid_rst_busy", inv_all_busy, 0);
        chk("mid_rst_cen", jtlb_data_cen, 0);
        m_sweep = -1; m_done = 0;
        @(posedge clk);
        #1 chk("mid_rst_done", inv_all_done, 0);
        @(negedge clk);
        rst = 0;
        step(0, 0, 1, 6'd0, 2'b00, 44'h0, 6'd0);
        repeat (67) step(0, 0, 0, 6'd0, 2'b00, 44'h0, 6'd0);
        step(0, 1, 0, 6'd0, 2'b00, 44'h0, 6'd20);

        // Randomized traffic; pending requests hold their payload until granted
        wp = 0; rp = 0; wi = 0; ri = 0; wy = 0; wd = 0;
        for (int k = 0; k < 600; k++) begin
            if (!wp && $urandom_range(0, 2) == 0) begin
                wp = 1; wi = 6'($urandom_range(0, 15)); wy = 2'($urandom);
                wd = 44'({$urandom(), $urandom()});
            end
            if (!rp && $urandom_range(0, 1) == 0) begin
                rp = 1; ri = 6'($urandom_range(0, 15));
            end
            step(wp, rp, $urandom_range(0, 149) == 0, wi, wy, wd, ri);
            if (last_wg) wp = 0;
            if (last_rg) rp = 0;
        end
        repeat (3) step(0, 0, 0, 6'd0, 2'b00, 44'h0, 6'd0);
        chk("rq_empty", rq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
